// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// byte-order rule used to assemble halfwords from the incoming byte stream.
package loader_pkg;

   typedef enum logic [3:0] {
      CNT_HI   = 4'd0,
      CNT_LO   = 4'd1,
      DAT_HI   = 4'd2,
      DAT_LO   = 4'd3,
      WR_SETUP = 4'd4,
      WR_PULSE = 4'd5,
      WR_HOLD  = 4'd6,
      CHK_HI   = 4'd7,
      CHK_LO   = 4'd8,
      RUN      = 4'd9,
      ERROR    = 4'd10
   } state_e;

   // The first byte of every pair is the most significant one.
   localparam int HI_BYTE_LSB = 8;

   // Assemble a halfword from two stream bytes in arrival order.
   function automatic logic [15:0] join_bytes(input logic [7:0] first_b,
                                              input logic [7:0] second_b);
      return (16'(first_b) << HI_BYTE_LSB) | 16'(second_b);
   endfunction

   // States in which the loader is willing to take a stream byte.
   function automatic logic accepts_bytes(input state_e s);
      logic r;
      case (s)
         CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake feeding the program loader.
interface prog_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader_sram_wr_strobe.sv
// Write-strobe timer: times the low phase of the SRAM write enable and
// tells the loader FSM when the pulse has lasted WR_LOW cycles.
module sram_wr_strobe
   import loader_pkg::*;
#(
   parameter int WR_LOW = 2
) (
   input  logic   clockFast,
   input  logic   reset,
   input  state_e state_q,
   output logic   wre_n,
   output logic   drive_en,
   output logic   pulse_last
);

   localparam logic [3:0] LAST_CNT = 4'(WR_LOW - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   assign pulse_last = (state_q == WR_PULSE) && (cnt_q == LAST_CNT);
   assign wre_n      = (state_q != WR_PULSE);
   assign drive_en   = (state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                       (state_q == WR_HOLD);

   // Count cycles spent in the low phase; restart from zero otherwise.
   always_comb begin
      cnt_d = 4'd0;
      if ((state_q == WR_PULSE) && !pulse_last) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = 4'd0;
      end
   end

   // Pulse counter register.
   always_ff @(posedge clockFast or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a counted, checksummed halfword image over a byte
// stream, writes it to SRAM from address 0, and releases the CPU on a good
// checksum. Once running, the SRAM bus is handed to the CPU combinationally.
module prog_loader
   import loader_pkg::*;
#(
   parameter int WR_LOW = 2,
   parameter int ADDR_W = 18
) (
   input  logic              clockFast,
   input  logic              reset,
   prog_loader_if.slave      in_if,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wre,
   input  logic [15:0]       cpu_wdata,
   output logic [15:0]       cpu_rdata,
   output logic              cpu_reset,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wre,
   inout  wire  [15:0]       ram_data,
   output logic              done,
   output logic              err
);

   state_e            state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       idx_q, idx_d;
   logic [15:0]       sum_q, sum_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cpu_reset_q, cpu_reset_d;

   logic              in_ready_s;
   logic              accept_s;
   logic [15:0]       hword_s;
   logic              more_s;
   logic              strobe_wre_n_s;
   logic              strobe_drive_s;
   logic              pulse_last_s;
   logic              run_s;
   logic              drive_s;
   logic [15:0]       drive_val_s;

   sram_wr_strobe #(.WR_LOW(WR_LOW)) u_strobe (
      .clockFast  (clockFast),
      .reset      (reset),
      .state_q    (state_q),
      .wre_n      (strobe_wre_n_s),
      .drive_en   (strobe_drive_s),
      .pulse_last (pulse_last_s)
   );

   assign in_ready_s     = accepts_bytes(state_q);
   assign in_if.in_ready = in_ready_s;
   assign accept_s       = in_if.in_valid && in_ready_s;
   assign hword_s        = join_bytes(hi_q, in_if.in_data);
   // 17-bit compare so N = 65535 completes without the index wrapping.
   assign more_s         = ({1'b0, idx_q} + 17'd1) < {1'b0, cnt_q};

   // Loader sequencing: parse the stream, schedule writes, verify checksum.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      case (state_q)
         CNT_HI: begin
            if (accept_s) begin
               hi_d    = in_if.in_data;
               state_d = CNT_LO;
            end else begin
               state_d = CNT_HI;
            end
         end
         CNT_LO: begin
            if (accept_s) begin
               cnt_d   = hword_s;
               idx_d   = 16'd0;
               sum_d   = 16'd0;
               state_d = (hword_s != 16'd0) ? DAT_HI : CHK_HI;
            end else begin
               state_d = CNT_LO;
            end
         end
         DAT_HI: begin
            if (accept_s) begin
               hi_d    = in_if.in_data;
               state_d = DAT_LO;
            end else begin
               state_d = DAT_HI;
            end
         end
         DAT_LO: begin
            if (accept_s) begin
               wdata_d = hword_s;
               addr_d  = ADDR_W'(idx_q);
               sum_d   = sum_q + hword_s;
               state_d = WR_SETUP;
            end else begin
               state_d = DAT_LO;
            end
         end
         WR_SETUP: begin
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (pulse_last_s) begin
               state_d = WR_HOLD;
            end else begin
               state_d = WR_PULSE;
            end
         end
         WR_HOLD: begin
            if (more_s) begin
               idx_d   = idx_q + 16'd1;
               state_d = DAT_HI;
            end else begin
               state_d = CHK_HI;
            end
         end
         CHK_HI: begin
            if (accept_s) begin
               hi_d    = in_if.in_data;
               state_d = CHK_LO;
            end else begin
               state_d = CHK_HI;
            end
         end
         CHK_LO: begin
            if (accept_s) begin
               state_d = (hword_s == sum_q) ? RUN : ERROR;
            end else begin
               state_d = CHK_LO;
            end
         end
         RUN:     state_d = RUN;
         ERROR:   state_d = ERROR;
         default: state_d = CNT_HI;
      endcase
      cpu_reset_d = (state_d != RUN);
   end

   // Loader state registers.
   always_ff @(posedge clockFast or posedge reset) begin
      if (reset) begin
         state_q     <= CNT_HI;
         hi_q        <= 8'd0;
         cnt_q       <= 16'd0;
         idx_q       <= 16'd0;
         sum_q       <= 16'd0;
         wdata_q     <= 16'd0;
         addr_q      <= '0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         wdata_q     <= wdata_d;
         addr_q      <= addr_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   // SRAM bus ownership: loader before RUN, CPU passthrough afterwards.
   assign run_s       = (state_q == RUN);
   assign ram_addr    = run_s ? cpu_addr : addr_q;
   assign ram_wre     = run_s ? cpu_wre  : strobe_wre_n_s;
   assign drive_s     = run_s ? ~cpu_wre : strobe_drive_s;
   assign drive_val_s = run_s ? cpu_wdata : wdata_q;
   assign ram_data    = drive_s ? drive_val_s : 16'hzzzz;
   assign cpu_rdata   = ram_data;

   assign cpu_reset   = cpu_reset_q;
   assign done        = run_s;
   assign err         = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader with an SRAM model on the bus.
module tb_prog_loader;

   localparam int WR_LOW = 3;
   localparam int ADDR_W = 18;

   logic              clockFast = 1'b0;
   logic              reset     = 1'b1;
   logic [ADDR_W-1:0] cpu_addr  = '0;
   logic              cpu_wre   = 1'b1;
   logic [15:0]       cpu_wdata = 16'd0;
   logic [15:0]       cpu_rdata;
   logic              cpu_reset;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wre;
   wire  [15:0]       ram_data;
   logic              done;
   logic              err;

   prog_loader_if bus ();

   always #5 clockFast = ~clockFast;

   prog_loader #(.WR_LOW(WR_LOW), .ADDR_W(ADDR_W)) dut (
      .clockFast (clockFast),
      .reset     (reset),
      .in_if     (bus),
      .cpu_addr  (cpu_addr),
      .cpu_wre   (cpu_wre),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_reset (cpu_reset),
      .ram_addr  (ram_addr),
      .ram_wre   (ram_wre),
      .ram_data  (ram_data),
      .done      (done),
      .err       (err)
   );

   // SRAM model: drives reads only once the CPU owns the bus.
   logic [15:0] mem [0:1023];
   assign ram_data = (done && ram_wre) ? mem[ram_addr[9:0]] : 16'hzzzz;
   always @(posedge clockFast) begin
      if (!ram_wre) mem[ram_addr[9:0]] <= ram_data;
   end

   typedef struct { logic [ADDR_W-1:0] a; logic [15:0] d; } wr_t;
   typedef struct { bit dn; bit er; } out_t;
   wr_t  wr_q[$];
   out_t out_q[$];
   logic [15:0] img[$];

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pulse timing, write contents and final outcome.
   initial begin
      int  low_cnt  = 0;
      int  busy_cnt = 0;
      bit  prev_wre = 1'b1;
      bit  prev_term = 1'b0;
      wr_t  w;
      out_t o;
      forever begin
         @(negedge clockFast);
         if (reset) begin
            low_cnt = 0; busy_cnt = 0; prev_wre = 1'b1; prev_term = 1'b0;
         end else begin
            if (mon_en && !done && !err) begin
               if (!ram_wre) begin
                  low_cnt++;
                  check("ready_low_in_write", 32'(bus.in_ready), 32'd0);
               end else if (!prev_wre) begin
                  check("pulse_len", 32'(low_cnt), 32'(WR_LOW));
                  if (wr_q.size() == 0) begin
                     check("unexpected_write", 32'd1, 32'd0);
                  end else begin
                     w = wr_q.pop_front();
                     check("wr_addr", 32'(ram_addr), 32'(w.a));
                     check("wr_data", 32'(ram_data), 32'(w.d));
                  end
                  low_cnt = 0;
               end
               if (!bus.in_ready) begin
                  busy_cnt++;
               end else if (busy_cnt != 0) begin
                  check("write_cycles", 32'(busy_cnt), 32'(WR_LOW + 2));
                  busy_cnt = 0;
               end
            end
            if (mon_en && (done || err) && !prev_term) begin
               if (out_q.size() == 0) begin
                  check("unexpected_end", 32'd1, 32'd0);
               end else begin
                  o = out_q.pop_front();
                  check("done", 32'(done), 32'(o.dn));
                  check("err", 32'(err), 32'(o.er));
                  check("cpu_reset", 32'(cpu_reset), 32'(!o.dn));
               end
            end
            prev_wre  = ram_wre;
            prev_term = done || err;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int gap;
      int guard;
      gap = $urandom_range(0, 3);
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clockFast);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(negedge clockFast);
         guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
      @(negedge clockFast);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
   endtask

   // Reference: sum of halfwords mod 2^16, writes to addresses 0..N-1.
   task automatic send_image(input logic [15:0] chk);
      logic [15:0] s;
      logic [15:0] n;
      int guard;
      s = 16'd0;
      n = 16'(img.size());
      foreach (img[k]) s = s + img[k];
      foreach (img[k]) wr_q.push_back('{ADDR_W'(k), img[k]});
      out_q.push_back('{chk == s, chk != s});
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      foreach (img[k]) begin
         send_byte(img[k][15:8]);
         send_byte(img[k][7:0]);
      end
      send_byte(chk[15:8]);
      send_byte(chk[7:0]);
      guard = 0;
      while (!(done || err) && guard < 200) begin
         @(negedge clockFast);
         guard++;
      end
      if (guard >= 200) check("terminal_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clockFast);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clockFast);
      #1 reset = 1'b0;
      @(negedge clockFast);
   endtask

   initial begin
      logic [15:0] s;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      repeat (2) @(negedge clockFast);
      // Reset state
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_ram_wre", 32'(ram_wre), 32'd1);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #1 reset = 1'b0;
      @(negedge clockFast);

      // Good two-word image, then CPU write/read passthrough
      img = '{16'h1234, 16'hABCD};
      send_image(16'hBE01);
      check("mem0", 32'(mem[0]), 32'h1234);
      check("mem1", 32'(mem[1]), 32'hABCD);
      cpu_addr = ADDR_W'(5); cpu_wdata = 16'h00FF; cpu_wre = 1'b0;
      @(negedge clockFast);
      check("run_addr", 32'(ram_addr), 32'd5);
      check("run_wre", 32'(ram_wre), 32'd0);
      check("run_wdata_bus", 32'(cpu_rdata), 32'h00FF);
      cpu_wre = 1'b1;
      @(negedge clockFast);
      check("mem5", 32'(mem[5]), 32'h00FF);
      check("run_rdata", 32'(cpu_rdata), 32'h00FF);
      cpu_addr = ADDR_W'(1);
      @(negedge clockFast);
      check("run_rdata1", 32'(cpu_rdata), 32'hABCD);

      // Bad checksum
      do_reset();
      send_image(16'hBE02);
      check("bad_mem1", 32'(mem[1]), 32'hABCD);

      // Empty image
      do_reset();
      img = {};
      send_image(16'h0000);

      // Reset during the write pulse of halfword 1
      do_reset();
      mon_en = 1'b0;
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h22);
      @(negedge clockFast);
      check("mid_pulse_wre", 32'(ram_wre), 32'd0);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_wre", 32'(ram_wre), 32'd1);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
      do_reset();
      mon_en = 1'b1;
      img = '{16'h5A5A, 16'hC3C3, 16'h0F0F};
      send_image(16'h5A5A + 16'hC3C3 + 16'h0F0F);
      check("reload_mem2", 32'(mem[2]), 32'h0F0F);

      // Randomised images, some with a corrupted checksum
      for (int t = 0; t < 8; t++) begin
         do_reset();
         img = {};
         s = 16'd0;
         for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
            img.push_back(16'($urandom));
            s = s + img[k];
         end
         if ($urandom_range(0, 3) == 0) s = s ^ (16'($urandom) | 16'd1);
         send_image(s);
         foreach (img[k]) check("rand_mem", 32'(mem[k]), 32'(img[k]));
      end

      check("wr_q_empty", 32'(wr_q.size()), 32'd0);
      check("out_q_empty", 32'(out_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
